// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter
//  Description : Up/down binary counter with a registered Gray-code mirror.
//                Supports a synchronous load and a terminal-event pulse.
//                The end-value behaviour is set by WRAP:
//                  WRAP = 1 : wrap modulo 2^WIDTH.
//                  WRAP = 0 : saturate at the end values.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_counter #(
    parameter int WIDTH = 3,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             term
);

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_MAX  = '1;
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_bin_q;
    logic [WIDTH-1:0] r_gray_q;
    logic             r_term_q;

    logic [WIDTH-1:0] w_bin_d;
    logic [WIDTH-1:0] w_gray_d;
    logic             w_term_d;

    // Next binary count and terminal flag: load beats enable, and both
    // end values are handled explicitly so wrap/saturate is a clean choice.
    always_comb begin
        w_bin_d  = r_bin_q;
        w_term_d = 1'b0;
        if (load) begin
            w_bin_d = load_bin;
        end else if (en) begin
            if (up) begin
                if (r_bin_q == C_MAX) begin
                    w_term_d = 1'b1;
                    if (WRAP) begin
                        w_bin_d = C_ZERO;
                    end
                end else begin
                    w_bin_d = r_bin_q + C_ONE;
                end
            end else begin
                if (r_bin_q == C_ZERO) begin
                    w_term_d = 1'b1;
                    if (WRAP) begin
                        w_bin_d = C_MAX;
                    end
                end else begin
                    w_bin_d = r_bin_q - C_ONE;
                end
            end
        end
    end

    // Gray encoding is derived from the next binary value, so the Gray
    // register always matches the binary register after every edge.
    assign w_gray_d[WIDTH-1] = w_bin_d[WIDTH-1];

    generate
        for (genvar i = 0; i < WIDTH - 1; i++) begin : g_gray
            assign w_gray_d[i] = w_bin_d[i+1] ^ w_bin_d[i];
        end
    endgenerate

    // State registers; reset overrides load and enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin_q  <= C_ZERO;
            r_gray_q <= C_ZERO;
            r_term_q <= 1'b0;
        end else begin
            r_bin_q  <= w_bin_d;
            r_gray_q <= w_gray_d;
            r_term_q <= w_term_d;
        end
    end

    assign bin_out  = r_bin_q;
    assign gray_out = r_gray_q;
    assign term     = r_term_q;

endmodule
`default_nettype wire
